// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: sequences the NEC IR decoder, validates captured frames and
// queues accepted command bytes for a valid/ready consumer.
module ir_cmd_ctrl #(
   parameter int unsigned HOLDOFF_CYCLES = 2_500_000,
   parameter logic [7:0]  ADDR           = 8'h00,
   parameter bit          ADDR_CHECK     = 1'b1,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        dec_ready,
   input  logic [31:0] dec_command,
   output logic        dec_enable,
   output logic        cmd_valid,
   output logic [7:0]  cmd_data,
   input  logic        cmd_ready,
   output logic [7:0]  err_cnt,
   output logic        overflow
);

   localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned HO_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LISTEN, CHECK, HOLDOFF} state_t;

   state_t             state, state_next;
   logic               ready_q;
   logic [31:0]        frame;
   logic [HO_W-1:0]    ho_cnt;
   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_next, wr_next;
   logic [CNT_W-1:0]   count, count_pop, count_next;
   logic               capture, accept, reject_sum, push, pop, ovf_set;
   logic               sum_ok, addr_ok;
   logic [7:0]         head_next;

   // Next-state decode, frame classification and FIFO bookkeeping
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      accept     = 1'b0;
      reject_sum = 1'b0;
      sum_ok     = (frame[7:0] == ~frame[15:8]) && (frame[23:16] == ~frame[31:24]);
      addr_ok    = !ADDR_CHECK || (frame[7:0] == ADDR);
      pop        = cmd_valid & cmd_ready;
      count_pop  = count - CNT_W'(pop);

      case (state)
         IDLE: begin
            if (run) state_next = LISTEN;
         end
         LISTEN: begin
            if (!run) begin
               state_next = IDLE;
            end else if (dec_ready && !ready_q) begin
               capture    = 1'b1;
               state_next = CHECK;
            end
         end
         CHECK: begin
            if (sum_ok && addr_ok) begin
               accept     = 1'b1;
               state_next = HOLDOFF;
            end else begin
               reject_sum = !sum_ok;
               state_next = run ? LISTEN : IDLE;
            end
         end
         HOLDOFF: begin
            if (ho_cnt == '0) state_next = run ? LISTEN : IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Full is judged after this cycle's pop
      push       = accept && (count_pop != CNT_FULL);
      ovf_set    = accept && !push;
      count_next = count_pop + CNT_W'(push);
      rd_next    = rd_ptr + PTR_W'(pop);
      wr_next    = wr_ptr + PTR_W'(push);

      if (count_next == '0)
         head_next = 8'h00;
      else if (count_pop == '0)
         head_next = frame[23:16];
      else
         head_next = mem[rd_next];
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Datapath, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q    <= 1'b0;
         frame      <= '0;
         ho_cnt     <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         dec_enable <= 1'b0;
         cmd_valid  <= 1'b0;
         cmd_data   <= 8'h00;
         err_cnt    <= 8'h00;
         overflow   <= 1'b0;
      end else begin
         ready_q <= dec_ready;
         if (capture) frame <= dec_command;
         if (accept)
            ho_cnt <= HO_LOAD;
         else if (state == HOLDOFF && ho_cnt != '0)
            ho_cnt <= ho_cnt - HO_W'(1);
         rd_ptr     <= rd_next;
         wr_ptr     <= wr_next;
         count      <= count_next;
         dec_enable <= (state_next == LISTEN);
         cmd_valid  <= (count_next != '0);
         cmd_data   <= head_next;
         if (reject_sum && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         if (ovf_set) overflow <= 1'b1;
      end
   end

   // Command storage
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= frame[23:16];
   end

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// Bench for ir_cmd_ctrl: two instances (address filter on / off) share the
// stimulus; a frame-level reference model predicts queue, error and overflow.
module tb_ir_cmd_ctrl;

   localparam int unsigned HOLD  = 16;
   localparam int unsigned DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst, run, dec_ready, cmd_ready;
   logic [31:0]       dec_command;
   logic [1:0]        en, vld, ovf;
   logic [1:0][7:0]   dat, errc;

   int checks = 0;
   int errors = 0;

   // reference model state per instance
   logic [7:0] mf [2][DEPTH];
   int         mcnt [2];
   int         merr [2];
   logic       movf [2];

   always #5 clk = ~clk;

   ir_cmd_ctrl #(.HOLDOFF_CYCLES(HOLD), .ADDR(8'h00), .ADDR_CHECK(1'b1), .FIFO_DEPTH(DEPTH)) u_dut0 (
      .clk(clk), .rst(rst), .run(run), .dec_ready(dec_ready), .dec_command(dec_command),
      .dec_enable(en[0]), .cmd_valid(vld[0]), .cmd_data(dat[0]), .cmd_ready(cmd_ready),
      .err_cnt(errc[0]), .overflow(ovf[0]));

   ir_cmd_ctrl #(.HOLDOFF_CYCLES(HOLD), .ADDR(8'h00), .ADDR_CHECK(1'b0), .FIFO_DEPTH(DEPTH)) u_dut1 (
      .clk(clk), .rst(rst), .run(run), .dec_ready(dec_ready), .dec_command(dec_command),
      .dec_enable(en[1]), .cmd_valid(vld[1]), .cmd_data(dat[1]), .cmd_ready(cmd_ready),
      .err_cnt(errc[1]), .overflow(ovf[1]));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
      return {~c, c, ~a, a};
   endfunction

   // 0 = checksum error, 1 = address drop, 2 = accepted
   function automatic int classify(input logic [31:0] f, input bit ac);
      logic [7:0] a, na, c, nc;
      a = f[7:0]; na = f[15:8]; c = f[23:16]; nc = f[31:24];
      if (((a ^ na) != 8'hFF) || ((c ^ nc) != 8'hFF)) return 0;
      if (ac && a != 8'h00) return 1;
      return 2;
   endfunction

   task automatic m_push(input int d, input logic [7:0] c);
      if (mcnt[d] == DEPTH) movf[d] = 1'b1;
      else begin
         mf[d][mcnt[d]] = c;
         mcnt[d]++;
      end
   endtask

   task automatic m_pop(input int d);
      if (mcnt[d] > 0) begin
         for (int k = 0; k < DEPTH - 1; k++) mf[d][k] = mf[d][k+1];
         mcnt[d]--;
      end
   endtask

   task automatic m_clear();
      for (int d = 0; d < 2; d++) begin
         mcnt[d] = 0; merr[d] = 0; movf[d] = 1'b0;
      end
   endtask

   task automatic check_dut(input int d, input string tag);
      check($sformatf("%s_valid%0d", tag, d), 32'(vld[d]), 32'(mcnt[d] != 0));
      check($sformatf("%s_data%0d", tag, d), 32'(dat[d]), 32'((mcnt[d] != 0) ? mf[d][0] : 8'h00));
      check($sformatf("%s_err%0d", tag, d), 32'(errc[d]), 32'(merr[d]));
      check($sformatf("%s_ovf%0d", tag, d), 32'(ovf[d]), 32'(movf[d]));
   endtask

   task automatic check_reset(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_en%0d", tag, d), 32'(en[d]), 32'd0);
         check($sformatf("%s_valid%0d", tag, d), 32'(vld[d]), 32'd0);
         check($sformatf("%s_data%0d", tag, d), 32'(dat[d]), 32'd0);
         check($sformatf("%s_err%0d", tag, d), 32'(errc[d]), 32'd0);
         check($sformatf("%s_ovf%0d", tag, d), 32'(ovf[d]), 32'd0);
      end
   endtask

   task automatic wait_listen(input string tag);
      int w;
      w = 0;
      while (en != 2'b11 && w < 200) begin
         step();
         w++;
      end
      check({tag, "_listen_timeout"}, 32'(en == 2'b11), 32'd1);
   endtask

   // One-cycle dec_ready pulse; returns at T+2 after checking both instances
   task automatic send_frame(input logic [31:0] f, input bit chk_hold, input string tag);
      int cls [2];
      wait_listen(tag);
      dec_command = f;
      dec_ready   = 1'b1;
      step();                                   // T+1
      check({tag, "_en_t1"}, 32'(en), 32'd0);
      dec_ready = 1'b0;
      step();                                   // T+2
      for (int d = 0; d < 2; d++) begin
         cls[d] = classify(f, d == 0);
         if (cls[d] == 0 && merr[d] < 255) merr[d]++;
         if (cls[d] == 2) m_push(d, f[23:16]);
         check_dut(d, tag);
         check($sformatf("%s_en_t2_%0d", tag, d), 32'(en[d]), 32'(cls[d] != 2));
      end
      if (chk_hold && cls[0] == 2) begin
         for (int i = 3; i <= HOLD + 1; i++) begin
            step();
            check($sformatf("%s_hold_t%0d", tag, i), 32'(en[0]), 32'd0);
         end
         step();                                // T+HOLD+2
         check({tag, "_en_back"}, 32'(en[0]), 32'd1);
      end
   endtask

   task automatic pop_one(input string tag);
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_pop(d);
         check_dut(d, tag);
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i <= DEPTH; i++) pop_one(tag);
   endtask

   function automatic logic [31:0] bad_frame();
      logic [31:0] f;
      logic [31:0] m;
      int          sel;
      f   = mk(8'($urandom), 8'($urandom));
      sel = $urandom_range(0, 3);
      m   = 32'($urandom_range(1, 255));
      return f ^ (m << (8 * sel));
   endfunction

   initial begin
      logic [31:0] f;
      int kind;

      rst = 1'b1; run = 1'b0; dec_ready = 1'b0; cmd_ready = 1'b0; dec_command = '0;
      m_clear();
      step(); step(); step();
      check_reset("reset");
      rst = 1'b0;
      step();
      check("idle_en", 32'(en), 32'd0);
      run = 1'b1;
      step();
      check("listen_en", 32'(en), 32'b11);

      // accepted frame with hold-off timing, then pop
      send_frame(32'hBF40_FF00, 1'b1, "accept");
      pop_one("accept_pop");

      // checksum failure
      send_frame(32'hBF41_FF00, 1'b0, "badsum");

      // address filter on instance 0, bypassed on instance 1
      send_frame(32'hBF40_FE01, 1'b0, "addr");
      drain("addr_drain");

      // error counter saturation
      for (int i = 0; i < 256; i++) send_frame(bad_frame(), 1'b0, "sat");
      check("sat_final", 32'(errc[0]), 32'd255);

      // overflow and ordering
      for (int i = 1; i <= 5; i++) send_frame(mk(8'h00, 8'(i)), 1'b0, "ovf");
      drain("ovf_drain");

      // randomized mix of frames and pops
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0:       f = mk(8'h00, 8'($urandom));
            1:       f = mk(8'($urandom), 8'($urandom));
            2:       f = bad_frame();
            default: f = '0;
         endcase
         if (kind == 3) pop_one("rnd_pop");
         else           send_frame(f, 1'b0, "rnd");
      end
      drain("rnd_drain");

      // dec_ready held high: one capture only
      wait_listen("held");
      f = mk(8'h00, 8'($urandom));
      dec_command = f;
      dec_ready   = 1'b1;
      for (int i = 0; i < 40; i++) step();
      dec_ready = 1'b0;
      m_push(0, f[23:16]);
      m_push(1, f[23:16]);
      step();
      for (int d = 0; d < 2; d++) check_dut(d, "held");
      pop_one("held_pop");

      // run dropped during hold-off
      send_frame(mk(8'h00, 8'h5A), 1'b0, "runoff");
      run = 1'b0;
      for (int i = 0; i < HOLD + 8; i++) begin
         step();
         check("runoff_en", 32'(en), 32'd0);
      end
      run = 1'b1;
      step();
      check("runon_en", 32'(en), 32'b11);
      drain("runoff_drain");

      // reset in hold-off with two queued entries
      send_frame(mk(8'h00, 8'hA1), 1'b0, "rstq");
      send_frame(mk(8'h00, 8'hA2), 1'b0, "rstq");
      rst = 1'b1;
      step();
      check_reset("midrst");
      rst = 1'b0;
      m_clear();
      step();
      check("postrst_en", 32'(en), 32'b11);
      for (int d = 0; d < 2; d++) check_dut(d, "postrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ir_cmd_ctrl.md
# ir_cmd_ctrl

Sequencer and command queue for the NEC IR decoder (`ir_decoder2`). It owns the decoder's `enable`, captures each 32-bit frame on `ready`, checks the NEC inverted-byte fields and the address, and queues accepted command bytes in a small FIFO. Consumers read the FIFO through a valid/ready handshake. After each accepted frame it gates the decoder off for a hold-off window so that key bounce and NEC repeat trains cannot flood the queue.

## Interface

Parameters:
- `HOLDOFF_CYCLES`, default 2_500_000: decoder-off window after an accepted frame (100 ms at 25 MHz). Must be ≥ 1.
- `ADDR`, default 8'h00: required NEC address.
- `ADDR_CHECK`, default 1: 1 drops frames whose address ≠ `ADDR`; 0 accepts any address.
- `FIFO_DEPTH`, default 4: number of command entries. Must be a power of two, ≥ 2.

Ports:
- `clk` in 1: single clock (25 MHz board clock).
- `rst` in 1: reset, synchronous, active-high.
- `run` in 1: 1 lets the controller listen; 0 parks it in IDLE.
- `dec_ready` in 1: decoder frame-done; may stay high more than one cycle.
- `dec_command` in 32: decoder frame. [7:0] addr, [15:8] ~addr, [23:16] cmd, [31:24] ~cmd.
- `dec_enable` out 1: drives decoder `enable`.
- `cmd_valid` out 1: FIFO non-empty.
- `cmd_data` out 8: head command byte; 8'h00 when the FIFO is empty.
- `cmd_ready` in 1: consumer pop; a pop occurs when `cmd_valid & cmd_ready`.
- `err_cnt` out 8: count of frames that failed the inverted-byte check; saturates at 255.
- `overflow` out 1: sticky; set when an accepted command is dropped because the FIFO is full.

## Operation

- States: IDLE, LISTEN, CHECK, HOLDOFF. `dec_enable` = 1 only in LISTEN.
- IDLE: if `run` = 1, go to LISTEN next cycle.
- LISTEN:
  - If `run` = 0, go to IDLE.
  - Else, on a `dec_ready` rising edge (`dec_ready` & ~previous `dec_ready`), register `dec_command` and go to CHECK.
  - A level held high yields exactly one capture.
- CHECK (one cycle):
  - Checksum failure: addr ≠ ~addr-field or cmd ≠ ~cmd-field. Increment `err_cnt` (saturating) and go to LISTEN.
  - Address mismatch with `ADDR_CHECK` = 1: drop silently; no counter change; go to LISTEN.
  - Otherwise the frame is accepted. Write the cmd byte into the FIFO, or set `overflow` if full. Load the hold-off counter with `HOLDOFF_CYCLES`-1 and go to HOLDOFF.
  - On exit from CHECK, if `run` = 0, go to IDLE instead of LISTEN.
- HOLDOFF: decrement the counter; at 0 go to LISTEN, or IDLE if `run` = 0.
- FIFO: read/write pointers plus a count; pointers wrap modulo `FIFO_DEPTH`.
  - Full is judged on the count at the CHECK cycle, with that cycle's pop applied first. A simultaneous pop and push at full is therefore accepted and the count is unchanged.
  - A pop when empty is ignored.
- The FIFO and handshake operate in every state, including IDLE.

## Timing

- Reset values: state IDLE, `dec_enable` 0, `cmd_valid` 0, `cmd_data` 8'h00, `err_cnt` 0, `overflow` 0, FIFO empty, hold-off counter 0, edge register 0.
- `rst` asserted in any state, including mid-HOLDOFF or mid-CHECK, gives reset values on the next cycle.
- Let T = the LISTEN cycle in which the `dec_ready` edge is seen.
- CHECK occurs at T+1; `dec_enable` goes low from T+1.
- Accepted frame:
  - Entry is visible from T+2: `cmd_valid` = 1 and `cmd_data` = cmd.
  - HOLDOFF covers T+2 .. T+HOLDOFF_CYCLES+1.
  - `dec_enable` returns high at T+HOLDOFF_CYCLES+2.
- Rejected or dropped frame: `dec_enable` is high again at T+2. `err_cnt` updates at T+2.
- A pop at cycle P advances the head at P+1.
- `overflow` is set at T+2.

## Test plan

- **Accepted frame** (`HOLDOFF_CYCLES`=16, `ADDR`=8'h00, `run`=1): one-cycle `dec_ready` with 32'hBF40_FF00. Expect `cmd_valid`=1 and `cmd_data`=8'h40 at T+2. Expect `dec_enable` low T+1..T+17 and high at T+18. Popping gives `cmd_valid`=0 and `cmd_data`=8'h00 next cycle.
- **Checksum failure**: frame 32'hBF41_FF00. Expect no push, `err_cnt`=1 at T+2, `dec_enable` high at T+2. After 256 bad frames, `err_cnt` = 255.
- **Address filter**: frame 32'hBF40_FE01. With `ADDR_CHECK`=1: dropped, `err_cnt` unchanged, `cmd_valid`=0. With `ADDR_CHECK`=0: `cmd_data`=8'h40.
- **Overflow and ordering**: `cmd_ready`=0; five valid frames with cmds 01, 02, 03, 04, 05. Expect FIFO holds 01..04 and `overflow`=1. Draining yields 01, 02, 03, 04 in order, then `cmd_valid`=0; `overflow` stays 1.
- **Held ready / run control**:
  - `dec_ready` held high for 40 cycles: exactly one push.
  - `run`=0 during HOLDOFF: state goes to IDLE at expiry and `dec_enable` stays 0.
  - `run`=1 again: `dec_enable`=1 one cycle later.
- **Reset mid-operation**: assert `rst` in HOLDOFF with 2 queued entries. Next cycle all outputs are at reset values and the FIFO is empty.
